// File: rtl/pwm_pkg.sv
// Shared constants, configuration payload and duty-compare helper for the PWM peripheral.
package pwm_pkg;

    localparam int unsigned PWM_CNT_W = 8;
    localparam int unsigned NUM_OUT   = 16;
    localparam int unsigned PRE_W     = 16;
    localparam int unsigned BYTE_W    = 8;

    localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;

    // Enable masks and requested duty as seen by the output stage.
    typedef struct packed {
        logic [NUM_OUT-1:0]   en_out;
        logic [NUM_OUT-1:0]   en_pwm;
        logic [PWM_CNT_W-1:0] duty;
    } pwm_cfg_t;

    // Full-scale duty is forced constant high rather than 255/256.
    function automatic logic pwm_level(input logic [PWM_CNT_W-1:0] cnt,
                                       input logic [PWM_CNT_W-1:0] duty);
        return (duty == DUTY_FULL) || (cnt < duty);
    endfunction

endpackage

// File: rtl/pwm_if.sv
// Configuration register bundle into the PWM peripheral and its output bundle back out.
interface pwm_if;
    import pwm_pkg::*;

    logic [BYTE_W-1:0]    en_reg_out_7_0;
    logic [BYTE_W-1:0]    en_reg_out_15_8;
    logic [BYTE_W-1:0]    en_reg_pwm_7_0;
    logic [BYTE_W-1:0]    en_reg_pwm_15_8;
    logic [PWM_CNT_W-1:0] pwm_duty_cycle;
    logic [NUM_OUT-1:0]   out;
    logic                 period_start;

    modport master (
        output en_reg_out_7_0,
        output en_reg_out_15_8,
        output en_reg_pwm_7_0,
        output en_reg_pwm_15_8,
        output pwm_duty_cycle,
        input  out,
        input  period_start
    );

    modport slave (
        input  en_reg_out_7_0,
        input  en_reg_out_15_8,
        input  en_reg_pwm_7_0,
        input  en_reg_pwm_15_8,
        input  pwm_duty_cycle,
        output out,
        output period_start
    );

endinterface

// File: rtl/pwm_timebase.sv
// Prescaler plus 8-bit period counter; flags the last tick of each 256-tick period.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int unsigned PRESCALE = 3000
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [PWM_CNT_W-1:0] pwm_cnt,
    output logic                 wrap_c
);

    if (PRESCALE == 0 || PRESCALE > 65535) begin : g_bad_prescale
        $error("pwm_timebase: PRESCALE must be in 1..65535");
    end

    localparam logic [PRE_W-1:0]     PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [PWM_CNT_W-1:0] CNT_LAST = {PWM_CNT_W{1'b1}};

    logic [PRE_W-1:0]     pre_cnt_q, pre_cnt_d;
    logic [PWM_CNT_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                 tick_c;

    // Counter advance; pwm_cnt wraps 255 -> 0 naturally.
    always_comb begin
        tick_c    = (pre_cnt_q == PRE_LAST);
        pre_cnt_d = pre_cnt_q + PRE_W'(1);
        pwm_cnt_d = pwm_cnt_q;
        if (tick_c) begin
            pre_cnt_d = '0;
            pwm_cnt_d = pwm_cnt_q + PWM_CNT_W'(1);
        end
        wrap_c = tick_c && (pwm_cnt_q == CNT_LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_cnt_q <= '0;
            pwm_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    assign pwm_cnt = pwm_cnt_q;

endmodule

// File: rtl/pwm_peripheral.sv
// PWM output stage: double-buffered duty, shared compare, per-bit enable mux into registered outputs.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int unsigned PRESCALE = 3000
) (
    input  logic  clk,
    input  logic  reset,
    pwm_if.slave  bus
);

    pwm_cfg_t             cfg_c;
    logic [PWM_CNT_W-1:0] pwm_cnt;
    logic                 wrap_c;
    logic                 pwm_sig_c;

    logic [PWM_CNT_W-1:0] duty_shadow_q, duty_shadow_d;
    logic [NUM_OUT-1:0]   out_q, out_d;
    logic                 period_start_q, period_start_d;

    pwm_timebase #(
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .clk     (clk),
        .reset   (reset),
        .pwm_cnt (pwm_cnt),
        .wrap_c  (wrap_c)
    );

    // Duty is only sampled on the wrap clk so a period is never cut short.
    always_comb begin
        cfg_c.en_out   = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
        cfg_c.en_pwm   = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
        cfg_c.duty     = bus.pwm_duty_cycle;

        duty_shadow_d  = duty_shadow_q;
        period_start_d = wrap_c;
        if (wrap_c) begin
            duty_shadow_d = cfg_c.duty;
        end

        pwm_sig_c = pwm_level(pwm_cnt, duty_shadow_q);
        out_d     = cfg_c.en_out & (~cfg_c.en_pwm | {NUM_OUT{pwm_sig_c}});
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            duty_shadow_q  <= '0;
            out_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            duty_shadow_q  <= duty_shadow_d;
            out_q          <= out_d;
            period_start_q <= period_start_d;
        end
    end

    assign bus.out          = out_q;
    assign bus.period_start = period_start_q;

endmodule
